// File: rtl/fp_exc_add_pipe_if.sv
// Handshake and data bundle for fp_exc_add_pipe.
// The master side supplies operand pairs and consumes results.
// The slave side is the exception-resolution pipeline.
interface fp_exc_add_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] q;
   logic         exc;
   logic         invalid;
   logic         sticky_inv;
   logic         sticky_clr;

   modport master (
      output in_valid, a, b, sub, out_ready, sticky_clr,
      input  in_ready, out_valid, q, exc, invalid, sticky_inv
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready, sticky_clr,
      output in_ready, out_valid, q, exc, invalid, sticky_inv
   );
endinterface

// File: rtl/fp_exc_add_pipe.sv
// Two-stage floating-point add/sub special-case resolver.
// Stage 1 classifies both operands; stage 2 holds the resolved
// special result (NaN, inf, zero pass-through) with its invalid flag.
// Optional feature macro: FP_EXC_STICKY_EN adds an accumulated
// invalid flag (sticky_inv) cleared by sticky_clr.
module fp_exc_add_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input logic               clk,
   input logic               rst_n,
   fp_exc_add_pipe_if.slave  bus
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [MAN_W-1:0] QBIT     = {1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
      logic snan;
   } cls_t;

   // Operand class from its exponent and fraction fields.
   function automatic cls_t classify(input logic [W-1:0] x);
      cls_t c;
      logic exp_ones, exp_zero, frac_zero;
      exp_ones  = (x[W-2:MAN_W] == EXP_ONES);
      exp_zero  = (x[W-2:MAN_W] == '0);
      frac_zero = (x[MAN_W-1:0] == '0);
      c.zero = exp_zero & frac_zero;
      c.inf  = exp_ones & frac_zero;
      c.nan  = exp_ones & ~frac_zero;
      c.snan = exp_ones & ~frac_zero & ~x[MAN_W-1];
      return c;
   endfunction

   // Stage 1 state
   logic         r_v1;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic         r_sb;
   cls_t         r_cls_a;
   cls_t         r_cls_b;

   // Stage 2 state
   logic         r_v2;
   logic [W-1:0] r_q;
   logic         r_exc;
   logic         r_inv;

   logic         w_s2_en;
   logic         w_s1_en;
   logic         w_in_fire;
   logic [W-1:0] w_q;
   logic         w_exc;
   logic         w_inv;

   // A stage may load when it is empty or its content moves on this cycle.
   assign w_s2_en   = ~r_v2 | bus.out_ready;
   assign w_s1_en   = ~r_v1 | w_s2_en;
   assign w_in_fire = bus.in_valid & w_s1_en;

   assign bus.in_ready  = w_s1_en;
   assign bus.out_valid = r_v2;
   assign bus.q         = r_q;
   assign bus.exc       = r_exc;
   assign bus.invalid   = r_inv;

   // Stage 1: capture operands, effective B sign and operand classes.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1    <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sb    <= 1'b0;
         r_cls_a <= '0;
         r_cls_b <= '0;
      end else if (w_s1_en) begin
         r_v1 <= w_in_fire;
         if (w_in_fire) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sb    <= bus.b[W-1] ^ bus.sub;
            r_cls_a <= classify(bus.a);
            r_cls_b <= classify(bus.b);
         end
      end
   end

   // Resolve the special case in priority order from the stage-1 classes.
   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_q   = '0;
      w_exc = 1'b0;
      w_inv = 1'b0;
      if (r_cls_a.nan || r_cls_b.nan) begin
         w_exc          = 1'b1;
         w_inv          = r_cls_a.snan | r_cls_b.snan;
         w_q            = r_cls_a.nan ? r_a : r_b;
         w_q[MAN_W-1]   = 1'b1;
      end else if (r_cls_a.inf && r_cls_b.inf && (r_a[W-1] != r_sb)) begin
         w_exc = 1'b1;
         w_inv = 1'b1;
         w_q   = {1'b0, EXP_ONES, QBIT};
      end else if (r_cls_a.inf) begin
         w_exc = 1'b1;
         w_q   = {r_a[W-1], EXP_ONES, {MAN_W{1'b0}}};
      end else if (r_cls_b.inf) begin
         w_exc = 1'b1;
         w_q   = {r_sb, EXP_ONES, {MAN_W{1'b0}}};
      end else if (r_cls_a.zero && r_cls_b.zero) begin
         w_exc = 1'b1;
         w_q   = {r_a[W-1] & r_sb, {(W-1){1'b0}}};
      end else if (r_cls_a.zero) begin
         w_exc = 1'b1;
         w_q   = {r_sb, r_b[W-2:0]};
      end else if (r_cls_b.zero) begin
         w_exc = 1'b1;
         w_q   = r_a;
      end
   end

   // Stage 2: register the resolved result; hold it while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2  <= 1'b0;
         r_q   <= '0;
         r_exc <= 1'b0;
         r_inv <= 1'b0;
      end else if (w_s2_en) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_q   <= w_q;
            r_exc <= w_exc;
            r_inv <= w_inv;
         end
      end
   end

`ifdef FP_EXC_STICKY_EN
   logic r_sticky;

   // Accumulate invalid on each delivered result; a new set beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
      end else if (r_v2 && bus.out_ready && r_inv) begin
         r_sticky <= 1'b1;
      end else if (bus.sticky_clr) begin
         r_sticky <= 1'b0;
      end
   end

   assign bus.sticky_inv = r_sticky;
`else
   logic w_unused_sticky_clr;

   assign w_unused_sticky_clr = bus.sticky_clr;
   assign bus.sticky_inv      = 1'b0;
`endif
endmodule

// File: tb/tb_fp_exc_add_pipe.sv
// Self-checking bench for fp_exc_add_pipe: directed cases, backpressure,
// mid-stream reset and a randomized stream against a field-level model.
module tb_fp_exc_add_pipe;
   logic clk;
   logic rst_n;

   fp_exc_add_pipe_if #(.EXP_W(5), .MAN_W(10)) bus ();
   fp_exc_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();

   fp_exc_add_pipe #(.EXP_W(5), .MAN_W(10)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   fp_exc_add_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] q;
      logic        exc;
      logic        inv;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   logic sticky_exp = 1'b0;
   logic acc;
   logic hs_out;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: IEEE special-case rules computed on unpacked fields.
   function automatic exp_t ref_model(input int ew, input int mw,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic sub);
      exp_t r;
      longint unsigned emax, fmask, qbit, sa, sb, ea, eb, fa, fb;
      bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
      emax  = (64'd1 << ew) - 1;
      fmask = (64'd1 << mw) - 1;
      qbit  = 64'd1 << (mw - 1);
      sa = (a >> (ew + mw)) & 1;
      sb = ((b >> (ew + mw)) & 1) ^ longint'(sub);
      ea = (a >> mw) & emax;  fa = a & fmask;
      eb = (b >> mw) & emax;  fb = b & fmask;
      a_nan  = (ea == emax) && (fa != 0);
      b_nan  = (eb == emax) && (fb != 0);
      a_snan = a_nan && ((fa & qbit) == 0);
      b_snan = b_nan && ((fb & qbit) == 0);
      a_inf  = (ea == emax) && (fa == 0);
      b_inf  = (eb == emax) && (fb == 0);
      a_zero = (ea == 0) && (fa == 0);
      b_zero = (eb == 0) && (fb == 0);
      r.exc = 1'b1;
      r.inv = 1'b0;
      if (a_nan || b_nan) begin
         r.q   = (a_nan ? a : b) | qbit;
         r.inv = a_snan || b_snan;
      end else if (a_inf && b_inf && (sa != sb)) begin
         r.q   = (emax << mw) | qbit;
         r.inv = 1'b1;
      end else if (a_inf) begin
         r.q = (sa << (ew + mw)) | (emax << mw);
      end else if (b_inf) begin
         r.q = (sb << (ew + mw)) | (emax << mw);
      end else if (a_zero && b_zero) begin
         r.q = (sa & sb) << (ew + mw);
      end else if (a_zero) begin
         r.q = (sb << (ew + mw)) | (eb << mw) | fb;
      end else if (b_zero) begin
         r.q = a;
      end else begin
         r.q   = 64'd0;
         r.exc = 1'b0;
      end
      return r;
   endfunction

   // Half-precision operand biased toward special classes.
   function automatic logic [15:0] rand_op();
      logic       s;
      logic [4:0] e;
      logic [9:0] f;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
         0:       begin e = 5'd0;  f = 10'd0; end
         1:       begin e = 5'd31; f = 10'd0; end
         2:       begin e = 5'd31; f = 10'h200 | 10'($urandom_range(0, 511)); end
         3:       begin e = 5'd31; f = 10'($urandom_range(1, 511)); end
         4:       begin e = 5'd0;  f = 10'($urandom_range(1, 1023)); end
         default: begin e = 5'($urandom_range(1, 30)); f = 10'($urandom_range(0, 1023)); end
      endcase
      return {s, e, f};
   endfunction

   // One clock of the 16-bit DUT: score outputs at negedge, advance to posedge+1.
   task automatic cycle();
      exp_t e;
      logic nxt;
      @(negedge clk);
      hs_out = bus.out_valid && bus.out_ready;
      acc    = bus.in_valid && bus.in_ready;
      nxt    = 1'b0;
      if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
         end else begin
            e = exp_q[0];
            check("q", 64'(bus.q), e.q);
            check("exc", 64'(bus.exc), 64'(e.exc));
            check("invalid", 64'(bus.invalid), 64'(e.inv));
`ifdef FP_EXC_STICKY_EN
            nxt = sticky_exp;
            if (hs_out && e.inv) nxt = 1'b1;
            else if (bus.sticky_clr) nxt = 1'b0;
`endif
            if (hs_out) void'(exp_q.pop_front());
         end
      end else begin
`ifdef FP_EXC_STICKY_EN
         nxt = bus.sticky_clr ? 1'b0 : sticky_exp;
`endif
      end
      if (acc) exp_q.push_back(ref_model(5, 10, 64'(bus.a), 64'(bus.b), bus.sub));
      @(posedge clk);
      #1;
      sticky_exp = nxt;
      check("sticky_inv", 64'(bus.sticky_inv), 64'(sticky_exp));
   endtask

   // Single pair with out_ready high: exact 2-cycle latency and literal result.
   task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [15:0] q_lit, input logic exc_lit, input logic inv_lit);
      bus.a = a; bus.b = b; bus.sub = sub;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      cycle();
      check("accept", 64'(acc), 64'd1);
      bus.in_valid = 1'b0;
      check("latency1_out_valid", 64'(bus.out_valid), 64'd0);
      cycle();
      check("latency2_out_valid", 64'(bus.out_valid), 64'd1);
      check("lit_q", 64'(bus.q), 64'(q_lit));
      check("lit_exc", 64'(bus.exc), 64'(exc_lit));
      check("lit_invalid", 64'(bus.invalid), 64'(inv_lit));
      cycle();
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] bp_a [4];
      logic [15:0] bp_b [4];
      int          idx;
      exp_t        r32;

      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0;
      bus.out_ready = 1'b1; bus.sticky_clr = 1'b0;
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0;
      bus32.out_ready = 1'b1; bus32.sticky_clr = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_q", 64'(bus.q), 64'd0);
      check("rst_exc", 64'(bus.exc), 64'd0);
      check("rst_invalid", 64'(bus.invalid), 64'd0);
      check("rst_sticky", 64'(bus.sticky_inv), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed special cases with literal expectations.
      send_one(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b1, 1'b1);
      send_one(16'h7D00, 16'h3C00, 1'b0, 16'h7F00, 1'b1, 1'b1);
      send_one(16'h3C00, 16'hFE01, 1'b0, 16'hFE01, 1'b1, 1'b0);
      send_one(16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0);
      send_one(16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
      send_one(16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b1, 1'b0);
      send_one(16'h3C00, 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0);
      send_one(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b1, 1'b1);
      send_one(16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 1'b1, 1'b0);
      send_one(16'h0001, 16'h7C00, 1'b1, 16'hFC00, 1'b1, 1'b0);

      // Backpressure: four pairs, consumer stalled for three cycles.
      bp_a[0] = 16'h7C00; bp_b[0] = 16'hFC00;
      bp_a[1] = 16'h0000; bp_b[1] = 16'h4400;
      bp_a[2] = 16'h7D55; bp_b[2] = 16'h0000;
      bp_a[3] = 16'h3C00; bp_b[3] = 16'h0000;
      bus.sub = 1'b0;
      bus.out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 3; c++) begin
         bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.in_valid = 1'b1;
         cycle();
         if (acc) idx++;
      end
      check("bp_accepts", 64'(idx), 64'd2);
      check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.in_valid = 1'b1;
         cycle();
         if (acc) idx++;
      end
      check("bp_all_accepted", 64'(idx), 64'd4);
      drain();

      // Reset with two items in flight.
      bus.out_ready = 1'b0;
      bus.a = 16'h7C00; bus.b = 16'hFC00; bus.in_valid = 1'b1;
      cycle();
      bus.a = 16'h7D00;
      cycle();
      check("inflight_count", 64'(exp_q.size()), 64'd2);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_sticky", 64'(bus.sticky_inv), 64'd0);
      exp_q.delete();
      sticky_exp = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      check("postrst_out_valid", 64'(bus.out_valid), 64'd0);
      send_one(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Randomized stream with random stalls and sticky clears.
      for (int i = 0; i < 400; i++) begin
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.a          = rand_op();
         bus.b          = rand_op();
         bus.sub        = 1'($urandom_range(0, 1));
         bus.out_ready  = ($urandom_range(0, 2) != 0);
         bus.sticky_clr = ($urandom_range(0, 7) == 0);
         cycle();
      end
      bus.sticky_clr = 1'b0;
      drain();

      // Single precision: inf - inf is invalid.
      bus32.a = 32'h7F80_0000; bus32.b = 32'h7F80_0000; bus32.sub = 1'b1;
      bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      check("sp_latency1", 64'(bus32.out_valid), 64'd0);
      @(posedge clk); #1;
      r32 = ref_model(8, 23, 64'h7F80_0000, 64'h7F80_0000, 1'b1);
      check("sp_out_valid", 64'(bus32.out_valid), 64'd1);
      check("sp_q", 64'(bus32.q), 64'h7FC0_0000);
      check("sp_q_model", 64'(bus32.q), r32.q);
      check("sp_invalid", 64'(bus32.invalid), 64'd1);
      check("sp_exc", 64'(bus32.exc), 64'd1);
      @(posedge clk); #1;
`ifdef FP_EXC_STICKY_EN
      check("sp_sticky_set", 64'(bus32.sticky_inv), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("sp_sticky_hold", 64'(bus32.sticky_inv), 64'd1);
      bus32.sticky_clr = 1'b1;
      @(posedge clk); #1;
      bus32.sticky_clr = 1'b0;
      check("sp_sticky_clr", 64'(bus32.sticky_inv), 64'd0);
`else
      check("sp_sticky_off", 64'(bus32.sticky_inv), 64'd0);
      bus32.sticky_clr = 1'b1;
      @(posedge clk); #1;
      bus32.sticky_clr = 1'b0;
      check("sp_sticky_off2", 64'(bus32.sticky_inv), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fp_exc_add_pipe.md
FP_EXC_ADD_PIPE -- requirements
Module: fp_exc_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent width.
REQ-002 SHALL have parameter MAN_W, default 10, fraction width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1  operand pair present.
REQ-006 SHALL have port in_ready  out  1  block accepts pair this cycle.
REQ-007 SHALL have port a  in  W  operand A {sign,exp,frac}.
REQ-008 SHALL have port b  in  W  operand B {sign,exp,frac}.
REQ-009 SHALL have port sub  in  1  1 = A-B, 0 = A+B.
REQ-010 SHALL have port out_valid  out  1  result present.
REQ-011 SHALL have port out_ready  in  1  consumer accepts result.
REQ-012 SHALL have port q  out  W  special-case result (0 when exc=0).
REQ-013 SHALL have port exc  out  1  special case resolved; normal datapath not needed.
REQ-014 SHALL have port invalid  out  1  IEEE invalid-operation for this result.
REQ-015 SHALL have port sticky_inv  out  1  accumulated invalid flag.
REQ-016 SHALL have port sticky_clr  in  1  clears sticky_inv.

Function
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers operand classes (zero, inf, qNaN, sNaN, finite) with effective sign sb = b[W-1]^sub; stage 2 registers resolved q/exc/invalid.
REQ-018 SHALL have latency exactly 2 cycles from accept (in_valid&in_ready) to out_valid with out_ready held 1; throughput 1 per cycle.
REQ-019 SHALL advance each stage when its register is empty or downstream accepts; in_ready = ~v1 | ~v2 | out_ready (combinational in out_ready).
REQ-020 SHALL hold q/exc/invalid stable while out_valid=1 and out_ready=0; no drop, no duplication, order preserved.
REQ-021 Resolution priority 1: any NaN -> A's NaN if A is NaN else B's, sign kept, frac MSB forced 1 (quieted); invalid=1 if either operand is sNaN (exp all-ones, frac MSB 0, frac nonzero).
REQ-022 Priority 2: A and B both inf with sign_a != sb -> canonical qNaN {0, all-ones, 1, zeros}, invalid=1.
REQ-023 Priority 3: either inf -> inf with that operand's effective sign (A's sign if A inf).
REQ-024 Priority 4: both zero -> zero with sign = sign_a & sb.
REQ-025 Priority 5: A zero -> {sb, b exp, b frac}; priority 6: B zero -> a unchanged.
REQ-026 Otherwise exc=0, invalid=0, q=0.
REQ-027 Subnormals SHALL be treated as finite (no exception).

Reset
REQ-028 rst_n=0 SHALL asynchronously clear both stage valids, q, exc, invalid, sticky_inv to 0; in-flight items discarded.
REQ-029 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-030 Reset deassertion mid-stream SHALL produce no out_valid until 2 cycles after a new accept.

Configuration
REQ-031 With FP_EXC_STICKY_EN defined, sticky_inv SHALL set on the cycle after any output handshake with invalid=1 and clear on sticky_clr; simultaneous set and clear SHALL leave it 1.
REQ-032 Without FP_EXC_STICKY_EN, sticky_inv SHALL be constant 0, sticky_clr ignored, no sticky register synthesised.

Verification
REQ-033 Default params, a=7C00, b=FC00, sub=0 -> q=7E00, exc=1, invalid=1, 2 cycles later.
REQ-034 a=7D00 (sNaN), b=3C00 -> q=7F00, exc=1, invalid=1; a=3C00, b=FE01 -> q=FE01, invalid=0.
REQ-035 a=8000,b=8000,sub=0 -> q=8000; a=8000,b=0000 -> q=0000; a=0000,b=3C00,sub=1 -> q=BC00; a=3C00,b=4000 -> exc=0,q=0000.
REQ-036 Stream 4 pairs back-to-back, out_ready=0 for 3 cycles: in_ready drops after 2 accepts; all 4 results delivered in order once out_ready=1.
REQ-037 rst_n low for 1 cycle with 2 items in flight -> out_valid=0, sticky_inv=0 immediately; next accept gives result 2 cycles later.
REQ-038 EXP_W=8, MAN_W=23, a=7F800000, b=7F800000, sub=1 -> q=7FC00000, invalid=1; with FP_EXC_STICKY_EN sticky_inv=1 until sticky_clr.
